// File: rtl/spu_pkg.sv
// ----------------------------------------------------------------------------
// spu_pkg
// Shared definitions for the odd-pipe issue stage:
//   - execution unit encodings (perm / local store / branch)
//   - producer latencies used to seed scoreboard countdowns
//   - bubble field constants for the issued-instruction register
//   - scoreboard entry record {valid, addr[7], count[5]}
//   - unit_latency(): countdown value for a producer of a given unit
// Configuration macro: ODD_FWD_EN
//   defined   : operands may be forwarded, countdowns are the raw latencies
//   undefined : operands only come from the register file, so every countdown
//               is extended until the value has been written back to the RF,
//               and the default scoreboard depth grows to 16
// ----------------------------------------------------------------------------
package spu_pkg;

    typedef enum logic [1:0] {
        UNIT_PERM = 2'd0,
        UNIT_LS   = 2'd1,
        UNIT_BR   = 2'd2
    } unit_e;

    localparam logic [4:0] LAT_PERM = 5'd4;
    localparam logic [4:0] LAT_LS   = 5'd6;
    localparam logic [4:0] LAT_BR   = 5'd1;

`ifdef ODD_FWD_EN
    localparam logic [4:0] LAT_EXTRA    = 5'd0;
    localparam int         SB_DEPTH_DEF = 8;
`else
    // Value must travel through fw[6], the writeback port and the RF write
    // before a reader may pick it up from rf_*.
    localparam logic [4:0] LAT_EXTRA    = 5'd9;
    localparam int         SB_DEPTH_DEF = 16;
`endif

    localparam logic [10:0] BUBBLE_OP     = 11'd0;
    localparam logic [2:0]  BUBBLE_FORMAT = 3'd0;
    localparam logic [1:0]  BUBBLE_UNIT   = 2'd0;
    localparam logic [17:0] BUBBLE_IMM    = 18'd0;

    typedef struct packed {
        logic       valid;
        logic [6:0] addr;
        logic [4:0] count;
    } sb_entry_t;

    function automatic logic [4:0] unit_latency(input logic [1:0] unit);
        logic [4:0] base;
        case (unit)
            UNIT_LS: base = LAT_LS;
            UNIT_BR: base = LAT_BR;
            default: base = LAT_PERM;
        endcase
        return base + LAT_EXTRA;
    endfunction

endpackage

// File: rtl/odd_scoreboard.sv
// ----------------------------------------------------------------------------
// odd_scoreboard
// Countdown scoreboard of in-flight odd-pipe producers.
//   clk, reset          : clock, synchronous active-high reset (clears all)
//   alloc               : an instruction writing alloc_addr issues this cycle
//   alloc_addr          : destination register of that instruction
//   alloc_count         : cycles until its result is readable
//   ra/rb/rc_addr, _used: sources of the instruction waiting in decode
//   hazard              : some used source matches a live entry
// Every live entry counts down by one per cycle and frees when it would reach
// zero. A reissue to an address already tracked overwrites that entry so a
// register never owns two entries.
// Configuration macro: ODD_FWD_EN (only affects the default depth)
// ----------------------------------------------------------------------------
module odd_scoreboard
    import spu_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alloc,
    input  logic [6:0] alloc_addr,
    input  logic [4:0] alloc_count,
    input  logic [6:0] ra_addr,
    input  logic [6:0] rb_addr,
    input  logic [6:0] rc_addr,
    input  logic       ra_used,
    input  logic       rb_used,
    input  logic       rc_used,
    output logic       hazard
);

    sb_entry_t entry_reg [SB_DEPTH];

    logic [SB_DEPTH-1:0] live;
    logic [SB_DEPTH-1:0] same_addr;
    logic [SB_DEPTH-1:0] free_vec;
    logic [SB_DEPTH-1:0] alloc_sel;
    logic [SB_DEPTH-1:0] hit_a;
    logic [SB_DEPTH-1:0] hit_b;
    logic [SB_DEPTH-1:0] hit_c;

    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_entry
            assign live[gi]      = entry_reg[gi].valid && (entry_reg[gi].count != 5'd0);
            assign same_addr[gi] = entry_reg[gi].valid && (entry_reg[gi].addr == alloc_addr);
            assign free_vec[gi]  = ~entry_reg[gi].valid;
            assign hit_a[gi]     = live[gi] && (entry_reg[gi].addr == ra_addr);
            assign hit_b[gi]     = live[gi] && (entry_reg[gi].addr == rb_addr);
            assign hit_c[gi]     = live[gi] && (entry_reg[gi].addr == rc_addr);
        end
    endgenerate

    // Prefer the entry already tracking this register; otherwise the lowest
    // free slot. x & ~(x-1) isolates the lowest set bit.
    always_comb begin
        alloc_sel = '0;
        if (|same_addr) begin
            alloc_sel = same_addr & ~(same_addr - SB_DEPTH'(1));
        end else begin
            alloc_sel = free_vec & ~(free_vec - SB_DEPTH'(1));
        end
    end

    assign hazard = (ra_used && (|hit_a)) ||
                    (rb_used && (|hit_b)) ||
                    (rc_used && (|hit_c));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (alloc && alloc_sel[i]) begin
                    entry_reg[i].valid <= 1'b1;
                    entry_reg[i].addr  <= alloc_addr;
                    entry_reg[i].count <= alloc_count;
                end else if (entry_reg[i].valid) begin
                    entry_reg[i].count <= entry_reg[i].count - 5'd1;
                    entry_reg[i].valid <= (entry_reg[i].count > 5'd1);
                end
            end
        end
    end

endmodule

// File: rtl/odd_fwd_issue.sv
// ----------------------------------------------------------------------------
// odd_fwd_issue
// Register-fetch / forwarding / issue stage in front of the odd pipe.
//   clk, reset                 : clock, synchronous active-high reset
//   in_valid / in_ready        : decode handshake (in_ready = ~hazard | flush)
//   in_op .. in_first          : decoded instruction fields
//   rf_ra / rf_rb / rf_rc      : same-cycle register-file read data
//   fw_wb, fw_addr_wb,
//   fw_write_wb                : odd-pipe forwarding window, index 0 youngest
//   rt_wb, rt_addr_wb,
//   reg_write_wb               : odd-pipe writeback port
//   flush                      : taken-branch flush, drops the input
//   op .. first, ra, rb, rt_st : registered issued instruction and operands
// Configuration macro: ODD_FWD_EN
//   defined   : operands select from fw window, then writeback, then RF
//   undefined : operands always from RF; forwarding inputs are ignored
// ----------------------------------------------------------------------------
module odd_fwd_issue
    import spu_pkg::*;
#(
    parameter int SB_DEPTH  = SB_DEPTH_DEF,
    parameter int FW_STAGES = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [10:0]                 in_op,
    input  logic [2:0]                  in_format,
    input  logic [1:0]                  in_unit,
    input  logic [6:0]                  in_rt_addr,
    input  logic [6:0]                  in_ra_addr,
    input  logic [6:0]                  in_rb_addr,
    input  logic [6:0]                  in_rc_addr,
    input  logic                        in_ra_used,
    input  logic                        in_rb_used,
    input  logic                        in_rc_used,
    input  logic [17:0]                 in_imm,
    input  logic                        in_reg_write,
    input  logic [7:0]                  in_pc,
    input  logic                        in_first,
    input  logic [127:0]                rf_ra,
    input  logic [127:0]                rf_rb,
    input  logic [127:0]                rf_rc,
    input  logic [FW_STAGES-1:0][127:0] fw_wb,
    input  logic [FW_STAGES-1:0][6:0]   fw_addr_wb,
    input  logic [FW_STAGES-1:0]        fw_write_wb,
    input  logic [127:0]                rt_wb,
    input  logic [6:0]                  rt_addr_wb,
    input  logic                        reg_write_wb,
    input  logic                        flush,
    output logic [10:0]                 op,
    output logic [2:0]                  format,
    output logic [1:0]                  unit,
    output logic [6:0]                  rt_addr,
    output logic [17:0]                 imm,
    output logic                        reg_write,
    output logic [7:0]                  pc_out,
    output logic                        first,
    output logic [127:0]                ra,
    output logic [127:0]                rb,
    output logic [127:0]                rt_st
);

    logic         hazard;
    logic         accept;
    logic [127:0] ra_sel;
    logic [127:0] rb_sel;
    logic [127:0] rc_sel;

    // Flush wins over a hazard: the instruction is consumed and discarded.
    assign in_ready = ~hazard | flush;
    assign accept   = in_valid & ~hazard & ~flush;

    odd_scoreboard #(
        .SB_DEPTH (SB_DEPTH)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .alloc       (accept & in_reg_write),
        .alloc_addr  (in_rt_addr),
        .alloc_count (unit_latency(in_unit)),
        .ra_addr     (in_ra_addr),
        .rb_addr     (in_rb_addr),
        .rc_addr     (in_rc_addr),
        .ra_used     (in_ra_used),
        .rb_used     (in_rb_used),
        .rc_used     (in_rc_used),
        .hazard      (hazard)
    );

`ifdef ODD_FWD_EN
    logic [FW_STAGES-1:0] fw_hit_a;
    logic [FW_STAGES-1:0] fw_hit_b;
    logic [FW_STAGES-1:0] fw_hit_c;

    generate
        for (genvar gi = 0; gi < FW_STAGES; gi++) begin : g_fw_hit
            assign fw_hit_a[gi] = fw_write_wb[gi] && (fw_addr_wb[gi] == in_ra_addr);
            assign fw_hit_b[gi] = fw_write_wb[gi] && (fw_addr_wb[gi] == in_rb_addr);
            assign fw_hit_c[gi] = fw_write_wb[gi] && (fw_addr_wb[gi] == in_rc_addr);
        end
    endgenerate

    // Walk from the oldest stage down so the youngest matching stage wins;
    // writeback and then the RF only serve when no stage matches.
    function automatic logic [127:0] pick(input logic [FW_STAGES-1:0] hit,
                                          input logic                 wb_hit,
                                          input logic [127:0]         rf_val);
        logic [127:0] val;
        val = wb_hit ? rt_wb : rf_val;
        for (int i = FW_STAGES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                val = fw_wb[i];
            end
        end
        return val;
    endfunction

    assign ra_sel = pick(fw_hit_a, reg_write_wb && (rt_addr_wb == in_ra_addr), rf_ra);
    assign rb_sel = pick(fw_hit_b, reg_write_wb && (rt_addr_wb == in_rb_addr), rf_rb);
    assign rc_sel = pick(fw_hit_c, reg_write_wb && (rt_addr_wb == in_rc_addr), rf_rc);
`else
    // Countdowns already cover the RF write, so the RF is always current.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{fw_wb, fw_addr_wb, fw_write_wb,
                                 rt_wb, rt_addr_wb, reg_write_wb};

    assign ra_sel = rf_ra;
    assign rb_sel = rf_rb;
    assign rc_sel = rf_rc;
`endif

    // Issue register. Bubbles clear every field except pc_out, which keeps
    // the last issued PC for downstream branch bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            op        <= BUBBLE_OP;
            format    <= BUBBLE_FORMAT;
            unit      <= BUBBLE_UNIT;
            rt_addr   <= '0;
            imm       <= BUBBLE_IMM;
            reg_write <= 1'b0;
            pc_out    <= '0;
            first     <= 1'b0;
            ra        <= '0;
            rb        <= '0;
            rt_st     <= '0;
        end else if (accept) begin
            op        <= in_op;
            format    <= in_format;
            unit      <= in_unit;
            rt_addr   <= in_rt_addr;
            imm       <= in_imm;
            reg_write <= in_reg_write;
            pc_out    <= in_pc;
            first     <= in_first;
            ra        <= ra_sel;
            rb        <= rb_sel;
            rt_st     <= rc_sel;
        end else begin
            op        <= BUBBLE_OP;
            format    <= BUBBLE_FORMAT;
            unit      <= BUBBLE_UNIT;
            rt_addr   <= '0;
            imm       <= BUBBLE_IMM;
            reg_write <= 1'b0;
            first     <= 1'b0;
            ra        <= '0;
            rb        <= '0;
            rt_st     <= '0;
        end
    end

endmodule

// File: tb/tb_odd_fwd_issue.sv
// ----------------------------------------------------------------------------
// tb_odd_fwd_issue
// Directed bench for odd_fwd_issue: a table of single-cycle operand-select
// vectors plus hand-written stall, flush and reset-during-stall sequences.
// Expected values follow the ODD_FWD_EN setting the bench is compiled with.
// ----------------------------------------------------------------------------
module tb_odd_fwd_issue;

`ifdef ODD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int XTRA = FWD ? 0 : 9;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [10:0]        in_op;
    logic [2:0]         in_format;
    logic [1:0]         in_unit;
    logic [6:0]         in_rt_addr, in_ra_addr, in_rb_addr, in_rc_addr;
    logic               in_ra_used, in_rb_used, in_rc_used;
    logic [17:0]        in_imm;
    logic               in_reg_write;
    logic [7:0]         in_pc;
    logic               in_first;
    logic [127:0]       rf_ra, rf_rb, rf_rc;
    logic [6:0][127:0]  fw_wb;
    logic [6:0][6:0]    fw_addr_wb;
    logic [6:0]         fw_write_wb;
    logic [127:0]       rt_wb;
    logic [6:0]         rt_addr_wb;
    logic               reg_write_wb;
    logic               flush;
    logic [10:0]        op;
    logic [2:0]         format;
    logic [1:0]         unit;
    logic [6:0]         rt_addr;
    logic [17:0]        imm;
    logic               reg_write;
    logic [7:0]         pc_out;
    logic               first;
    logic [127:0]       ra, rb, rt_st;

    int total = 0;
    int bad   = 0;

    odd_fwd_issue dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_format    (in_format),
        .in_unit      (in_unit),
        .in_rt_addr   (in_rt_addr),
        .in_ra_addr   (in_ra_addr),
        .in_rb_addr   (in_rb_addr),
        .in_rc_addr   (in_rc_addr),
        .in_ra_used   (in_ra_used),
        .in_rb_used   (in_rb_used),
        .in_rc_used   (in_rc_used),
        .in_imm       (in_imm),
        .in_reg_write (in_reg_write),
        .in_pc        (in_pc),
        .in_first     (in_first),
        .rf_ra        (rf_ra),
        .rf_rb        (rf_rb),
        .rf_rc        (rf_rc),
        .fw_wb        (fw_wb),
        .fw_addr_wb   (fw_addr_wb),
        .fw_write_wb  (fw_write_wb),
        .rt_wb        (rt_wb),
        .rt_addr_wb   (rt_addr_wb),
        .reg_write_wb (reg_write_wb),
        .flush        (flush),
        .op           (op),
        .format       (format),
        .unit         (unit),
        .rt_addr      (rt_addr),
        .imm          (imm),
        .reg_write    (reg_write),
        .pc_out       (pc_out),
        .first        (first),
        .ra           (ra),
        .rb           (rb),
        .rt_st        (rt_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed data patterns: fw stage k carries bytes F0+k, writeback EE,
    // register file 0A/0B/0C per source.
    localparam logic [127:0] WBV  = {16{8'hEE}};
    localparam logic [127:0] RFA  = {16{8'h0A}};
    localparam logic [127:0] RFB  = {16{8'h0B}};
    localparam logic [127:0] RFC  = {16{8'h0C}};

    function automatic logic [127:0] fwdat(input int k);
        logic [7:0] b;
        b = 8'hF0 + k[7:0];
        return {16{b}};
    endfunction

    // Source code: 0..6 fw stage, 7 writeback, 8 register file.
    function automatic logic [127:0] srcval(input int code, input logic [127:0] rfv);
        if (code <= 6) return fwdat(code);
        if (code == 7) return WBV;
        return rfv;
    endfunction

    typedef struct {
        logic [6:0]      ra_a;
        logic [6:0]      rb_a;
        logic [6:0]      rc_a;
        logic [6:0]      fw_we;
        logic [6:0][6:0] fw_a;
        logic            wb_en;
        logic [6:0]      wb_a;
        int              exp_ra;
        int              exp_rb;
        int              exp_rc;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        in_op        = '0;
        in_format    = '0;
        in_unit      = '0;
        in_rt_addr   = '0;
        in_ra_addr   = '0;
        in_rb_addr   = '0;
        in_rc_addr   = '0;
        in_ra_used   = 1'b0;
        in_rb_used   = 1'b0;
        in_rc_used   = 1'b0;
        in_imm       = '0;
        in_reg_write = 1'b0;
        in_pc        = '0;
        in_first     = 1'b0;
        fw_write_wb  = '0;
        reg_write_wb = 1'b0;
        flush        = 1'b0;
    endtask

    // Count cycles with in_ready low (bounded) and confirm each produced a bubble.
    task automatic wait_stalls(input string nm, input int exp);
        int n;
        bit bub_bad;
        n = 0;
        bub_bad = 1'b0;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (op !== 11'd0 || reg_write !== 1'b0) bub_bad = 1'b1;
        end
        chk({nm, "_stalls"}, n, exp);
        chk({nm, "_bubbles"}, bub_bad, 1'b0);
    endtask

    // Producer of unit punit writes r; next instruction reads r through src.
    task automatic raw_seq(input string nm, input logic [1:0] punit, input logic [6:0] r,
                           input int src, input int exp_stalls);
        logic [127:0] fwv, rfv, got;
        fwv = {8{16'hAAAA}};
        rfv = {8{16'h5555}};
        idle();
        in_valid = 1'b1; in_op = {4'h4, r}; in_unit = punit; in_rt_addr = r;
        in_reg_write = 1'b1; in_pc = 8'h80; in_format = 3'd1;
        #1 chk({nm, "_prod_ready"}, in_ready, 1'b1);
        tick();
        chk({nm, "_prod_op"}, op, {4'h4, r});
        chk({nm, "_prod_unit"}, unit, punit);
        chk({nm, "_prod_rt"}, rt_addr, r);
        chk({nm, "_prod_rw"}, reg_write, 1'b1);
        in_op = 11'h3C5; in_unit = 2'd0; in_rt_addr = 7'd0; in_reg_write = 1'b0; in_pc = 8'h81;
        case (src)
            0:       begin in_ra_addr = r; in_ra_used = 1'b1; end
            1:       begin in_rb_addr = r; in_rb_used = 1'b1; end
            default: begin in_rc_addr = r; in_rc_used = 1'b1; end
        endcase
        fw_write_wb = 7'b0000100; fw_addr_wb[2] = r; fw_wb[2] = fwv;
        rf_ra = rfv; rf_rb = rfv; rf_rc = rfv;
        #1;
        wait_stalls(nm, exp_stalls);
        tick();
        got = (src == 0) ? ra : (src == 1) ? rb : rt_st;
        chk({nm, "_dep_op"}, op, 11'h3C5);
        chk({nm, "_dep_operand"}, got, FWD ? fwv : rfv);
        $display("txn %s: expected stalls %0d, operand %h", nm, exp_stalls, got);
        idle();
        repeat (20) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{7'd3, 7'd4, 7'd5, 7'b0010010,
                    {7'd0, 7'd0, 7'd3, 7'd0, 7'd0, 7'd3, 7'd0}, 1'b0, 7'd0, 1, 8, 8};
        vecs[1] = '{7'd10, 7'd11, 7'd12, 7'b1111111,
                    {7'd12, 7'd11, 7'd10, 7'd12, 7'd10, 7'd11, 7'd20}, 1'b0, 7'd0, 2, 1, 3};
        vecs[2] = '{7'd6, 7'd6, 7'd7, 7'b1000000,
                    {7'd7, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, 1'b1, 7'd6, 7, 7, 6};
        vecs[3] = '{7'd8, 7'd9, 7'd0, 7'b0101000,
                    {7'd0, 7'd9, 7'd0, 7'd0, 7'd0, 7'd0, 7'd8}, 1'b0, 7'd8, 8, 5, 3};
        vecs[4] = '{7'd15, 7'd15, 7'd16, 7'b1000000,
                    {7'd15, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, 1'b1, 7'd15, 6, 6, 8};
        vecs[5] = '{7'd0, 7'd0, 7'd0, 7'b0000000,
                    {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, 1'b1, 7'd0, 7, 7, 7};

        idle();
        fw_wb = '0; fw_addr_wb = '0; rt_wb = '0; rt_addr_wb = '0;
        rf_ra = '0; rf_rb = '0; rf_rc = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_op", op, 11'd0);
        chk("rst_format", format, 3'd0);
        chk("rst_unit", unit, 2'd0);
        chk("rst_rt", rt_addr, 7'd0);
        chk("rst_imm", imm, 18'd0);
        chk("rst_rw", reg_write, 1'b0);
        chk("rst_pc", pc_out, 8'd0);
        chk("rst_ra", ra, 128'd0);
        chk("rst_rtst", rt_st, 128'd0);
        chk("rst_ready", in_ready, 1'b1);
        $display("txn reset: outputs cleared");

        // Operand-select table: no producers in flight, so every vector issues.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_op = 11'h100 + 11'(i); in_pc = 8'h40 + 8'(i);
            in_unit = 2'd0; in_reg_write = 1'b0;
            in_ra_used = 1'b1; in_rb_used = 1'b1; in_rc_used = 1'b1;
            in_ra_addr = vecs[i].ra_a; in_rb_addr = vecs[i].rb_a; in_rc_addr = vecs[i].rc_a;
            fw_write_wb = vecs[i].fw_we;
            for (int k = 0; k < 7; k++) begin
                fw_addr_wb[k] = vecs[i].fw_a[k];
                fw_wb[k] = fwdat(k);
            end
            reg_write_wb = vecs[i].wb_en; rt_addr_wb = vecs[i].wb_a; rt_wb = WBV;
            rf_ra = RFA; rf_rb = RFB; rf_rc = RFC;
            #1 chk($sformatf("v%0d_ready", i), in_ready, 1'b1);
            tick();
            chk($sformatf("v%0d_op", i), op, 11'h100 + 11'(i));
            chk($sformatf("v%0d_pc", i), pc_out, 8'h40 + 8'(i));
            chk($sformatf("v%0d_ra", i), ra, srcval(FWD ? vecs[i].exp_ra : 8, RFA));
            chk($sformatf("v%0d_rb", i), rb, srcval(FWD ? vecs[i].exp_rb : 8, RFB));
            chk($sformatf("v%0d_rtst", i), rt_st, srcval(FWD ? vecs[i].exp_rc : 8, RFC));
            $display("txn vec%0d: ra=%h", i, ra);
        end
        idle();
        tick();

        // Single perm writing r5.
        in_valid = 1'b1; in_op = 11'h123; in_format = 3'd5; in_unit = 2'd0;
        in_rt_addr = 7'd5; in_reg_write = 1'b1; in_imm = 18'h2ABCD; in_pc = 8'h10; in_first = 1'b1;
        #1 chk("p5_ready", in_ready, 1'b1);
        tick();
        idle();
        #1 chk("p5_ready_after", in_ready, 1'b1);
        chk("p5_op", op, 11'h123);
        chk("p5_format", format, 3'd5);
        chk("p5_unit", unit, 2'd0);
        chk("p5_rt", rt_addr, 7'd5);
        chk("p5_rw", reg_write, 1'b1);
        chk("p5_imm", imm, 18'h2ABCD);
        chk("p5_pc", pc_out, 8'h10);
        chk("p5_first", first, 1'b1);
        tick();
        chk("p5_bubble_op", op, 11'd0);
        chk("p5_bubble_imm", imm, 18'd0);
        chk("p5_pc_hold", pc_out, 8'h10);
        $display("txn perm_r5: issued op %h", 11'h123);
        repeat (20) tick();

        raw_seq("perm_ra", 2'd0, 7'd5, 0, 4 + XTRA);
        raw_seq("ls_rc", 2'd1, 7'd9, 2, 6 + XTRA);
        raw_seq("br_rb", 2'd2, 7'd11, 1, 1 + XTRA);

        // Flush during a stall: dropped, bubble out, entry still blocks.
        idle();
        in_valid = 1'b1; in_op = 11'h207; in_unit = 2'd0; in_rt_addr = 7'd7;
        in_reg_write = 1'b1; in_pc = 8'h88;
        tick();
        in_op = 11'h2AA; in_rt_addr = 7'd0; in_reg_write = 1'b0; in_pc = 8'h89;
        in_ra_addr = 7'd7; in_ra_used = 1'b1;
        #1 chk("fl_stall_ready", in_ready, 1'b0);
        tick();
        flush = 1'b1;
        #1 chk("fl_ready", in_ready, 1'b1);
        tick();
        chk("fl_bubble_op", op, 11'd0);
        chk("fl_bubble_rw", reg_write, 1'b0);
        chk("fl_pc_hold", pc_out, 8'h88);
        flush = 1'b0;
        #1;
        wait_stalls("fl", 4 + XTRA - 2);
        tick();
        chk("fl_accept_op", op, 11'h2AA);
        $display("txn flush: reader issued after %0d remaining stalls", 4 + XTRA - 2);
        idle();
        repeat (20) tick();

        // Reset in the middle of a stall clears the scoreboard.
        in_valid = 1'b1; in_op = 11'h20C; in_unit = 2'd0; in_rt_addr = 7'd12;
        in_reg_write = 1'b1; in_pc = 8'hA0;
        tick();
        in_op = 11'h1E1; in_rt_addr = 7'd0; in_reg_write = 1'b0; in_pc = 8'hA1;
        in_ra_addr = 7'd12; in_ra_used = 1'b1;
        #1 chk("rs_stall_ready", in_ready, 1'b0);
        tick();
        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
        chk("rs_op", op, 11'd0);
        chk("rs_pc", pc_out, 8'd0);
        in_valid = 1'b1;
        #1 chk("rs_ready", in_ready, 1'b1);
        tick();
        chk("rs_accept_op", op, 11'h1E1);
        $display("txn reset_mid_stall: reader issued immediately");
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
